// File: rtl/shifter_pkg.sv
// Shared types and op_field bit positions for the operand-2 shifter pipeline.
package shifter_pkg;

  typedef enum logic [2:0] {
    LSL = 3'd0,
    LSR = 3'd1,
    ASR = 3'd2,
    ROR = 3'd3,
    RRX = 3'd4
  } shift_type_e;

  // Normalised amounts never exceed N+1 (N <= 64), so 7 bits always suffice.
  localparam int AMT_W = 7;

  localparam int OP_IMM8_LSB  = 0;
  localparam int OP_IMM8_MSB  = 7;
  localparam int OP_ROT_LSB   = 8;
  localparam int OP_ROT_MSB   = 11;
  localparam int OP_REGSH_BIT = 4;
  localparam int OP_TYPE_LSB  = 5;
  localparam int OP_TYPE_MSB  = 6;
  localparam int OP_SHIMM_LSB = 7;
  localparam int OP_SHIMM_MSB = 11;

  typedef struct packed {
    shift_type_e            stype;
    logic [AMT_W-1:0]       amt;
    logic                   cin;
  } stage_ctrl_t;

endpackage

// File: rtl/shift_core.sv
// Combinational barrel shift and carry for a pre-normalised type/amount pair.
module shift_core
  import shifter_pkg::*;
#(
  parameter int N = 32
) (
  input  shift_type_e      stype,
  input  logic [AMT_W-1:0] amt,
  input  logic [N-1:0]     rm,
  input  logic             cin,
  output logic [N-1:0]     result,
  output logic             carry
);

  localparam logic [N-1:0] ONE = N'(1);

  logic signed [N-1:0] rm_s;
  int unsigned         a;

  assign rm_s = rm;

  // Amount 0 passes rm and cin through; ROR amounts arrive already reduced to 1..N.
  always_comb begin
    result = rm;
    carry  = cin;
    a      = 32'(amt);
    if (a != 0) begin
      case (stype)
        LSL: begin
          if (a < N) begin
            result = rm << a;
            carry  = |(rm & (ONE << (N - a)));
          end else begin
            result = '0;
            carry  = (a == N) ? rm[0] : 1'b0;
          end
        end
        LSR: begin
          if (a < N) begin
            result = rm >> a;
            carry  = |(rm & (ONE << (a - 1)));
          end else begin
            result = '0;
            carry  = (a == N) ? rm[N-1] : 1'b0;
          end
        end
        ASR: begin
          if (a < N) begin
            result = $unsigned(rm_s >>> a);
            carry  = |(rm & (ONE << (a - 1)));
          end else begin
            result = {N{rm[N-1]}};
            carry  = rm[N-1];
          end
        end
        ROR: begin
          result = (rm >> a) | (rm << (N - a));
          carry  = result[N-1];
        end
        default: ;
      endcase
    end
    if (stype == RRX) begin
      result = {cin, rm[N-1:1]};
      carry  = rm[0];
    end
  end

endmodule

// File: rtl/shifter_pipe.sv
// Two-stage operand-2 shifter: S1 decodes and registers operands, S2 shifts and registers the result.
module shifter_pipe
  import shifter_pkg::*;
#(
  parameter int N       = 32,
  parameter int SHAMT_W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         imm_mode,
  input  logic [11:0]  op_field,
  input  logic [N-1:0] rm,
  input  logic [N-1:0] rs,
  input  logic         cin,
  input  logic         use_shifter,
  input  logic [N-1:0] direct_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] operand2,
  output logic         c_out
);

  localparam int RAW_W = (SHAMT_W > 5) ? SHAMT_W : 5;

  // Fold every register/immediate corner case into a core amount: ROR -> 1..N, others clamp at N+1.
  function automatic logic [AMT_W-1:0] norm_amt(input shift_type_e t, input logic [RAW_W-1:0] a);
    int unsigned ai;
    int unsigned m;
    ai = 32'(a);
    if (t == ROR) begin
      m = ai & (N - 1);
      if (ai != 0 && m == 0) m = N;
    end else begin
      m = (ai > N) ? N + 1 : ai;
    end
    return AMT_W'(m);
  endfunction

  stage_ctrl_t      ctrl_d, ctrl_p1;
  logic [N-1:0]     rm_d, rm_p1;
  shift_type_e      stype_d;
  logic [RAW_W-1:0] raw_d;
  logic             vld_p1, vld_p2;
  logic             s1_adv, accept;
  logic [N-1:0]     core_res;
  logic             core_c;
  logic             unused_rs_hi;

  assign unused_rs_hi = ^rs[N-1:SHAMT_W];

  always_comb begin
    rm_d    = rm;
    stype_d = LSL;
    raw_d   = '0;
    if (!use_shifter) begin
      rm_d = direct_data;
    end else if (imm_mode) begin
      rm_d    = N'(op_field[OP_IMM8_MSB:OP_IMM8_LSB]);
      stype_d = ROR;
      raw_d   = RAW_W'({op_field[OP_ROT_MSB:OP_ROT_LSB], 1'b0});
    end else begin
      stype_d = shift_type_e'({1'b0, op_field[OP_TYPE_MSB:OP_TYPE_LSB]});
      if (op_field[OP_REGSH_BIT])
        raw_d = RAW_W'(rs[SHAMT_W-1:0]);
      else
        raw_d = RAW_W'(op_field[OP_SHIMM_MSB:OP_SHIMM_LSB]);
    end
    ctrl_d.stype = stype_d;
    ctrl_d.amt   = norm_amt(stype_d, raw_d);
    ctrl_d.cin   = cin;
    // Immediate #0 encodes LSR/ASR #N and RRX; LSL #0 already means pass-through.
    if (use_shifter && !imm_mode && !op_field[OP_REGSH_BIT] &&
        op_field[OP_SHIMM_MSB:OP_SHIMM_LSB] == 5'd0) begin
      if (stype_d == LSR || stype_d == ASR)
        ctrl_d.amt = AMT_W'(N);
      else if (stype_d == ROR)
        ctrl_d.stype = RRX;
    end
  end

  assign s1_adv    = vld_p1 & (~vld_p2 | out_ready);
  assign in_ready  = ~rst & ~flush & (~vld_p1 | s1_adv);
  assign accept    = in_valid & in_ready;
  assign out_valid = vld_p2;

  shift_core #(.N(N)) u_core (
    .stype  (ctrl_p1.stype),
    .amt    (ctrl_p1.amt),
    .rm     (rm_p1),
    .cin    (ctrl_p1.cin),
    .result (core_res),
    .carry  (core_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1   <= 1'b0;
      vld_p2   <= 1'b0;
      ctrl_p1  <= '0;
      rm_p1    <= '0;
      operand2 <= '0;
      c_out    <= 1'b0;
    end else begin
      // S1 boundary: decoded control and operand
      if (accept) begin
        ctrl_p1 <= ctrl_d;
        rm_p1   <= rm_d;
      end
      // S2 boundary: shifted result and carry
      if (s1_adv) begin
        operand2 <= core_res;
        c_out    <= core_c;
      end
      if (flush) begin
        vld_p1 <= 1'b0;
        vld_p2 <= 1'b0;
      end else begin
        if (accept)      vld_p1 <= 1'b1;
        else if (s1_adv) vld_p1 <= 1'b0;
        if (s1_adv)         vld_p2 <= 1'b1;
        else if (out_ready) vld_p2 <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_shifter_pipe.sv
// Directed bench for shifter_pipe (N=32): corner-case shifts, latency, backpressure, flush and reset.
module tb_shifter_pipe;

  localparam int N       = 32;
  localparam int SHAMT_W = 8;

  logic         clk = 1'b0;
  logic         rst, flush, in_valid, in_ready, imm_mode;
  logic [11:0]  op_field;
  logic [N-1:0] rm, rs, direct_data, operand2;
  logic         cin, use_shifter, out_valid, out_ready, c_out;

  int checks = 0;
  int errors = 0;

  shifter_pipe #(.N(N), .SHAMT_W(SHAMT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .imm_mode    (imm_mode),
    .op_field    (op_field),
    .rm          (rm),
    .rs          (rs),
    .cin         (cin),
    .use_shifter (use_shifter),
    .direct_data (direct_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .operand2    (operand2),
    .c_out       (c_out)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [N-1:0] exp, input logic exp_c);
    check({tag, "/valid"}, 64'(out_valid), 64'd1);
    check({tag, "/op2"}, 64'(operand2), 64'(exp));
    check({tag, "/c"}, 64'(c_out), 64'(exp_c));
  endtask

  task automatic set_req(input logic imm, input logic [11:0] op, input logic [N-1:0] a_rm,
                         input logic [N-1:0] a_rs, input logic a_cin);
    use_shifter = 1'b1;
    imm_mode    = imm;
    op_field    = op;
    rm          = a_rm;
    rs          = a_rs;
    cin         = a_cin;
  endtask

  // Issue whatever is on the request inputs and check the 2-cycle latency and result.
  task automatic run_cur(input string tag, input logic [N-1:0] exp, input logic exp_c);
    in_valid = 1'b1;
    #1;
    check({tag, "/rdy"}, 64'(in_ready), 64'd1);
    step();
    in_valid = 1'b0;
    #1;
    check({tag, "/lat1"}, 64'(out_valid), 64'd0);
    step();
    check_out(tag, exp, exp_c);
    step();
    check({tag, "/drain"}, 64'(out_valid), 64'd0);
  endtask

  task automatic run_one(input string tag, input logic imm, input logic [11:0] op,
                         input logic [N-1:0] a_rm, input logic [N-1:0] a_rs, input logic a_cin,
                         input logic [N-1:0] exp, input logic exp_c);
    set_req(imm, op, a_rm, a_rs, a_cin);
    run_cur(tag, exp, exp_c);
  endtask

  // Fill both stages: A = LSL #1 of 1 (-> 2), B = LSL #4 of 3 (-> 0x30).
  task automatic fill_two();
    set_req(1'b0, 12'h080, 32'h1, 32'h0, 1'b0);
    in_valid = 1'b1;
    #1;
    check("fillA/rdy", 64'(in_ready), 64'd1);
    step();
    set_req(1'b0, 12'h200, 32'h3, 32'h0, 1'b0);
    #1;
    check("fillB/rdy", 64'(in_ready), 64'd1);
    step();
    check_out("fillA", 32'h2, 1'b0);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    imm_mode = 1'b0; op_field = '0; rm = '0; rs = '0; cin = 1'b0;
    use_shifter = 1'b1; direct_data = '0;

    repeat (3) step();
    check("rst/valid", 64'(out_valid), 64'd0);
    check("rst/op2", 64'(operand2), 64'd0);
    check("rst/c", 64'(c_out), 64'd0);
    check("rst/rdy", 64'(in_ready), 64'd0);
    rst = 1'b0;
    #1;
    check("rst/rdy_after", 64'(in_ready), 64'd1);

    run_one("imm_rot", 1'b1, 12'h4FF, 32'h0, 32'h0, 1'b0, 32'hFF000000, 1'b1);
    run_one("lsl_r1", 1'b0, 12'h010, 32'h80000001, 32'd1, 1'b0, 32'h00000002, 1'b1);
    run_one("lsl_r32", 1'b0, 12'h010, 32'h80000001, 32'd32, 1'b0, 32'h0, 1'b1);
    run_one("lsl_r33", 1'b0, 12'h010, 32'h80000001, 32'd33, 1'b1, 32'h0, 1'b0);
    run_one("lsl_r0", 1'b0, 12'h010, 32'h80000001, 32'd0, 1'b1, 32'h80000001, 1'b1);
    run_one("lsr_i0", 1'b0, 12'h020, 32'h80000000, 32'h0, 1'b0, 32'h0, 1'b1);
    run_one("asr_i0", 1'b0, 12'h040, 32'h80000000, 32'h0, 1'b0, 32'hFFFFFFFF, 1'b1);
    run_one("rrx", 1'b0, 12'h060, 32'h00000003, 32'h0, 1'b1, 32'h80000001, 1'b1);
    run_one("ror_r32", 1'b0, 12'h070, 32'h80000001, 32'd32, 1'b0, 32'h80000001, 1'b1);
    run_one("ror_r4", 1'b0, 12'h070, 32'h0000000F, 32'd4, 1'b0, 32'hF0000000, 1'b1);
    run_one("asr_r40", 1'b0, 12'h050, 32'h80000000, 32'd40, 1'b0, 32'hFFFFFFFF, 1'b1);
    run_one("lsr_i4", 1'b0, 12'h220, 32'h000000F8, 32'h0, 1'b0, 32'h0000000F, 1'b1);
    run_one("ror_i8", 1'b0, 12'h460, 32'h123456F8, 32'h0, 1'b0, 32'hF8123456, 1'b1);
    run_one("lsl_i0", 1'b0, 12'h000, 32'h00000005, 32'h0, 1'b1, 32'h00000005, 1'b1);

    use_shifter = 1'b0; direct_data = 32'h12345678; cin = 1'b0;
    run_cur("direct", 32'h12345678, 1'b0);

    // Backpressure: r1 LSL#1 of 1, r2 LSL#4 of 3, r3 LSL#1 of 0xC0000000.
    out_ready = 1'b0;
    set_req(1'b0, 12'h080, 32'h1, 32'h0, 1'b0);
    in_valid = 1'b1;
    #1;
    check("bp/r1_rdy", 64'(in_ready), 64'd1);
    step();
    set_req(1'b0, 12'h200, 32'h3, 32'h0, 1'b0);
    #1;
    check("bp/r2_rdy", 64'(in_ready), 64'd1);
    step();
    set_req(1'b0, 12'h080, 32'hC0000000, 32'h0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      #1;
      check("bp/r3_stall", 64'(in_ready), 64'd0);
      check_out("bp/hold", 32'h2, 1'b0);
      step();
    end
    out_ready = 1'b1;
    #1;
    check("bp/r3_rdy", 64'(in_ready), 64'd1);
    check_out("bp/out1", 32'h2, 1'b0);
    step();
    in_valid = 1'b0;
    check_out("bp/out2", 32'h30, 1'b0);
    step();
    check_out("bp/out3", 32'h80000000, 1'b1);
    step();
    check("bp/empty", 64'(out_valid), 64'd0);

    // Flush with two requests in flight and a new one offered.
    fill_two();
    set_req(1'b0, 12'h010, 32'hFFFFFFFF, 32'd1, 1'b0);
    flush = 1'b1;
    #1;
    check("flush/rdy", 64'(in_ready), 64'd0);
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    #1;
    check("flush/valid1", 64'(out_valid), 64'd0);
    step();
    check("flush/valid2", 64'(out_valid), 64'd0);
    run_one("post_flush", 1'b0, 12'h070, 32'h000000F0, 32'd4, 1'b1, 32'h0000000F, 1'b0);

    // Reset for one cycle with both stages full.
    fill_two();
    set_req(1'b0, 12'h010, 32'hFFFFFFFF, 32'd1, 1'b0);
    rst = 1'b1;
    #1;
    check("mrst/rdy_in", 64'(in_ready), 64'd0);
    step();
    check("mrst/valid", 64'(out_valid), 64'd0);
    check("mrst/op2", 64'(operand2), 64'd0);
    check("mrst/c", 64'(c_out), 64'd0);
    check("mrst/rdy", 64'(in_ready), 64'd0);
    rst = 1'b0;
    in_valid = 1'b0;
    #1;
    check("mrst/rdy_after", 64'(in_ready), 64'd1);
    for (int i = 0; i < 3; i++) begin
      step();
      check("mrst/no_stale", 64'(out_valid), 64'd0);
    end
    run_one("post_rst", 1'b1, 12'h1FF, 32'h0, 32'h0, 1'b0, 32'hC000003F, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/shifter_pipe.md
SHIFTER_PIPE -- requirements
Module: shifter_pipe

Interface
REQ-001 Parameter N, default 32, datapath width; legal values are powers of two from 8 to 64.
REQ-002 Parameter SHAMT_W, default 8, width of the register-sourced shift amount taken from rs[SHAMT_W-1:0].
REQ-003 clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 rst  in  1  reset, synchronous and active-high.
REQ-005 flush  in  1  synchronous pipeline kill.
REQ-006 in_valid  in  1  request present.
REQ-007 in_ready  out  1  request accepted when in_valid and in_ready are both high.
REQ-008 imm_mode  in  1  instruction bit 25: 1 selects rotated immediate, 0 selects shifted register.
REQ-009 op_field  in  12  instruction bits 11:0.
REQ-010 rm, rs  in  N each  register operand and shift-amount register.
REQ-011 cin  in  1  current C flag.
REQ-012 use_shifter  in  1  0 forwards direct_data unshifted; direct_data  in  N.
REQ-013 out_valid  out  1; out_ready  in  1; operand2  out  N; c_out  out  1.

Function
REQ-014 imm_mode=1 SHALL produce zero-extended op_field[7:0] rotated right by 2*op_field[11:8]; c_out is cin when the rotate amount is 0, otherwise operand2[N-1].
REQ-015 imm_mode=0 SHALL decode shift type from op_field[6:5] (00 LSL, 01 LSR, 10 ASR, 11 ROR); op_field[4]=0 takes the amount from op_field[11:7]; op_field[4]=1 takes the amount from rs[SHAMT_W-1:0]; op_field[3:0] is ignored.
REQ-016 Immediate amount 0: LSL gives rm with c_out=cin; LSR gives 0 with c_out=rm[N-1]; ASR gives all bits equal to rm[N-1] with c_out=rm[N-1]; ROR gives RRX, i.e. {cin, rm[N-1:1]} with c_out=rm[0].
REQ-017 Register amount 0 SHALL give operand2=rm and c_out=cin for every shift type.
REQ-018 Register LSL/LSR with amount==N SHALL give 0 with c_out=rm[0] (LSL) or rm[N-1] (LSR); amount>N SHALL give 0 with c_out=0.
REQ-019 Register ASR with amount>=N SHALL give all bits equal to rm[N-1] with c_out=rm[N-1].
REQ-020 Register ROR SHALL rotate by amount mod N; a nonzero amount with amount mod N == 0 gives operand2=rm and c_out=rm[N-1].
REQ-021 In all other nonzero-amount cases, c_out is the last bit shifted out.
REQ-022 use_shifter=0 SHALL give operand2=direct_data and c_out=cin.
REQ-023 The block is a two-stage pipeline: S1 registers the decoded type and amount plus the operands; S2 registers operand2 and c_out. An accepted request appears at the output exactly 2 cycles later when out_ready is held high.
REQ-024 Throughput SHALL be one request per cycle with no bubbles while out_ready=1.
REQ-025 A stage loads when it is empty or when its contents advance in the same cycle; in_ready = !flush && (S1 empty || S1 advances).
REQ-026 While out_valid=1 and out_ready=0, operand2, c_out and out_valid SHALL remain stable.
REQ-027 Results SHALL leave in acceptance order, with no loss or duplication.
REQ-028 flush SHALL invalidate S1 and S2 on the next edge; with flush and in_valid both high, the request is not accepted. An output handshake in the flush cycle completes normally.

Reset
REQ-029 With rst high at an edge, out_valid=0, operand2=0, c_out=0 and both stage valids are cleared, overriding flush and any handshake.
REQ-030 in_ready SHALL be 0 while rst is high and 1 on the first cycle after reset is released.
REQ-031 Assertion of rst mid-operation SHALL discard all in-flight requests, and no stale result appears afterwards.

Structure
REQ-032 Package shifter_pkg SHALL hold shift_type_e (LSL, LSR, ASR, ROR, RRX), op_field bit-position constants and the stage payload struct.
REQ-033 The combinational shift and carry logic SHALL live in sub-module shift_core (inputs: type, amount, rm, cin; outputs: result, carry), instantiated once in S2.
REQ-034 Only the valid bits and payload registers are reset; there are no latches, and every combinational output has a default.

Verification (N=32)
REQ-035 Rotated immediate: imm_mode=1, op_field=0x4FF -> operand2=0xFF000000, c_out=1, out_valid exactly 2 cycles after acceptance.
REQ-036 Register LSL: rm=0x80000001 with rs=1 -> 0x00000002, c=1; rs=32 -> 0, c=1; rs=33 -> 0, c=0; rs=0 with cin=1 -> 0x80000001, c=1.
REQ-037 Immediate specials: LSR #0 with rm=0x80000000 -> 0, c=1; ASR #0 -> 0xFFFFFFFF, c=1; RRX with cin=1, rm=0x00000003 -> 0x80000001, c=1.
REQ-038 Backpressure: 3 back-to-back requests with out_ready=0 for 4 cycles -> the third request is stalled (in_ready=0) and the output is held stable; on release, the 3 results arrive in order on consecutive cycles.
REQ-039 Flush: flush=1 with 2 requests in flight and in_valid=1 -> out_valid=0 next cycle, the new request is not accepted, and the next accepted request produces the correct result 2 cycles later.
REQ-040 Reset mid-stream: rst=1 for 1 cycle with both stages full -> all outputs 0 and in_ready=0 during reset; no stale out_valid afterwards.
